// File: rtl/opensync_rewrite_engine_pkg.sv
// opensync_pkg: shared encodings for the OpenSync/TSMP rewrite engine.
//   action_e : rule action (PASS / TO_NODE / TO_CTRL / DROP)
//   state_e  : rewrite FSM states
//   slot_t   : one lookahead window stage {valid, frame flag, byte}
package opensync_pkg;

  typedef enum logic [1:0] {
    ACT_PASS    = 2'd0,
    ACT_TO_NODE = 2'd1,
    ACT_TO_CTRL = 2'd2,
    ACT_DROP    = 2'd3
  } action_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // Bytes 12..14 written on frames rewritten toward a node
  localparam logic [7:0] NODE_B12 = 8'hff;
  localparam logic [7:0] NODE_B13 = 8'h01;
  localparam logic [7:0] NODE_B14 = 8'h06;

  localparam logic [7:0] SUB_FROM_CTRL = 8'h01;
  localparam logic [7:0] SUB_TO_CTRL   = 8'h02;
  localparam logic [7:0] SUB_TO_NODE   = 8'h03;

  localparam int unsigned BEAT_W = 9;

  typedef struct packed {
    logic       valid;
    logic       flag;
    logic [7:0] data;
  } slot_t;

  localparam int unsigned SLOT_W = $bits(slot_t);

endpackage

// File: rtl/opensync_rewrite_engine_if.sv
// Byte-stream bus of the rewrite engine: 9-bit beats (bit 8 = first/last flag)
// in and out, each with a write strobe.
//   master : frame source / sink side (drives iv_data, i_data_wr)
//   slave  : rewrite engine side (drives ov_data, o_data_wr)
interface opensync_rewrite_engine_if;
  logic [8:0] iv_data;
  logic       i_data_wr;
  logic [8:0] ov_data;
  logic       o_data_wr;

  modport master (output iv_data, output i_data_wr, input ov_data, input o_data_wr);
  modport slave  (input iv_data, input i_data_wr, output ov_data, output o_data_wr);
endinterface

// File: rtl/opensync_rewrite_engine_delay_line.sv
// tsmp_delay_line: DELAY-stage shift register of {valid, beat}.
//   i_clk, i_rst_n       : clock, synchronous active-low reset (clears all stages)
//   iv_data, i_data_wr   : incoming beat; absent beats enter as valid=0, data 0
//   ov_tail              : oldest stage (window position 0)
//   ov_win_valid/flag    : bit p-1 = valid/flag of window position p, p=1..MATCH_OFFSET
//   ov_match_byte        : byte at window position MATCH_OFFSET
module tsmp_delay_line
  import opensync_pkg::*;
#(
  parameter int unsigned DELAY        = 32,
  parameter int unsigned MATCH_OFFSET = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [BEAT_W-1:0]       iv_data,
  input  logic                    i_data_wr,
  output slot_t                   ov_tail,
  output logic [MATCH_OFFSET-1:0] ov_win_valid,
  output logic [MATCH_OFFSET-1:0] ov_win_flag,
  output logic [7:0]              ov_match_byte
);

  slot_t [DELAY-1:0] stage_q;
  slot_t             in_slot;

  assign in_slot = i_data_wr ? slot_t'({1'b1, iv_data}) : '0;

  // Stage 0 takes the new beat; stage DELAY-1 is the tail
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DELAY-2:0], in_slot};
    end
  end

  assign ov_tail       = stage_q[DELAY-1];
  assign ov_match_byte = stage_q[DELAY-1-MATCH_OFFSET].data;

  // Window position p sits p stages ahead of the tail
  always_comb begin
    ov_win_valid = '0;
    ov_win_flag  = '0;
    for (int unsigned p = 1; p <= MATCH_OFFSET; p++) begin
      ov_win_valid[p-1] = stage_q[DELAY-1-p].valid;
      ov_win_flag[p-1]  = stage_q[DELAY-1-p].flag;
    end
  end

endmodule

// File: rtl/opensync_rewrite_engine.sv
// opensync_rewrite_engine: rule-driven OpenSync/TSMP frame rewriter.
//   i_clk, i_rst_n              : clock, synchronous active-low reset
//   iv_hcp_mac, iv_controller_mac: MACs inserted by TO_CTRL rewrites
//   iv_rule_*                   : per-rule enable / match subtype / action / new subtype
//   bus (slave)                 : 9-bit beat stream in and out, DELAY+1 cycle latency
//   i_cnt_clr                   : synchronous clear of all counters (beats increments)
//   ov_rx/fwd/drop_cnt          : saturating frames decided / forwarded / dropped
module opensync_rewrite_engine
  import opensync_pkg::*;
#(
  parameter int unsigned DELAY        = 32,
  parameter int unsigned MATCH_OFFSET = 15,
  parameter int unsigned NUM_RULES    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [47:0]            iv_hcp_mac,
  input  logic [47:0]            iv_controller_mac,
  input  logic [NUM_RULES-1:0]   iv_rule_en,
  input  logic [8*NUM_RULES-1:0] iv_rule_subtype,
  input  logic [2*NUM_RULES-1:0] iv_rule_action,
  input  logic [8*NUM_RULES-1:0] iv_rule_new_subtype,
  opensync_rewrite_engine_if.slave bus,
  input  logic                   i_cnt_clr,
  output logic [CNT_W-1:0]       ov_rx_cnt,
  output logic [CNT_W-1:0]       ov_fwd_cnt,
  output logic [CNT_W-1:0]       ov_drop_cnt
);

  localparam int unsigned IDX_W = $clog2(MATCH_OFFSET + 1) + 1;

  slot_t                   tail;
  logic [MATCH_OFFSET-1:0] win_valid;
  logic [MATCH_OFFSET-1:0] win_flag;
  logic [7:0]              match_byte;

  state_e           state_q;
  action_e          act_q;
  logic [7:0]       new_sub_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] rx_cnt_q, fwd_cnt_q, drop_cnt_q;

  tsmp_delay_line #(
    .DELAY        (DELAY),
    .MATCH_OFFSET (MATCH_OFFSET)
  ) u_delay_line (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .iv_data       (bus.iv_data),
    .i_data_wr     (bus.i_data_wr),
    .ov_tail       (tail),
    .ov_win_valid  (win_valid),
    .ov_win_flag   (win_flag),
    .ov_match_byte (match_byte)
  );

  // Head detection and runt check on the window contents
  logic    head_c, runt_c;
  action_e match_act_c, dec_act_c;
  logic [7:0] match_sub_c;

  assign head_c = (state_q == ST_IDLE) && tail.valid && tail.flag;
  assign runt_c = (~win_valid != '0) || (win_flag != '0);

  // Priority encoder: lowest-index enabled matching rule wins, no match drops
  always_comb begin
    match_act_c = ACT_DROP;
    match_sub_c = 8'h00;
    for (int r = NUM_RULES - 1; r >= 0; r--) begin
      if (iv_rule_en[r] && (iv_rule_subtype[8*r +: 8] == match_byte)) begin
        match_act_c = action_e'(iv_rule_action[2*r +: 2]);
        match_sub_c = iv_rule_new_subtype[8*r +: 8];
      end
    end
  end

  assign dec_act_c = runt_c ? ACT_DROP : match_act_c;

  // Header byte rewrite; byte 0 is rewritten in the decision cycle itself
  action_e          act_c;
  logic [7:0]       sub_c, out_byte_c;
  logic [IDX_W-1:0] idx_c;
  logic             hdr_c;

  always_comb begin
    act_c      = (state_q == ST_IDLE) ? dec_act_c : act_q;
    sub_c      = (state_q == ST_IDLE) ? match_sub_c : new_sub_q;
    idx_c      = (state_q == ST_IDLE) ? '0 : idx_q;
    hdr_c      = head_c || (state_q == ST_HDR);
    out_byte_c = tail.data;
    if (hdr_c) begin
      for (int unsigned b = 0; b < 6; b++) begin
        if (act_c == ACT_TO_CTRL && b < MATCH_OFFSET && idx_c == IDX_W'(b))
          out_byte_c = iv_controller_mac[8*(5-b) +: 8];
        if (act_c == ACT_TO_CTRL && (b + 6) < MATCH_OFFSET && idx_c == IDX_W'(b + 6))
          out_byte_c = iv_hcp_mac[8*(5-b) +: 8];
      end
      if (act_c == ACT_TO_NODE && MATCH_OFFSET > 12 && idx_c == IDX_W'(12)) out_byte_c = NODE_B12;
      if (act_c == ACT_TO_NODE && MATCH_OFFSET > 13 && idx_c == IDX_W'(13)) out_byte_c = NODE_B13;
      if (act_c == ACT_TO_NODE && MATCH_OFFSET > 14 && idx_c == IDX_W'(14)) out_byte_c = NODE_B14;
      if (act_c != ACT_DROP && idx_c == IDX_W'(MATCH_OFFSET)) out_byte_c = sub_c;
    end
  end

  // Rewrite FSM with registered output beat
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      act_q         <= ACT_PASS;
      new_sub_q     <= 8'h00;
      idx_q         <= '0;
      bus.ov_data   <= '0;
      bus.o_data_wr <= 1'b0;
    end else begin
      bus.ov_data   <= '0;
      bus.o_data_wr <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (head_c) begin
            act_q     <= dec_act_c;
            new_sub_q <= match_sub_c;
            idx_q     <= IDX_W'(1);
            if (dec_act_c == ACT_DROP) begin
              state_q <= ST_DROP;
            end else begin
              state_q       <= ST_HDR;
              bus.ov_data   <= {tail.flag, out_byte_c};
              bus.o_data_wr <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          bus.ov_data   <= {tail.flag, out_byte_c};
          bus.o_data_wr <= 1'b1;
          idx_q         <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(MATCH_OFFSET)) state_q <= ST_BODY;
        end
        ST_BODY: begin
          if (tail.valid) begin
            bus.ov_data   <= {tail.flag, out_byte_c};
            bus.o_data_wr <= 1'b1;
          end
          // Frames are contiguous, so a hole also ends the frame
          if (!tail.valid || tail.flag) state_q <= ST_IDLE;
        end
        ST_DROP: begin
          if (!tail.valid || tail.flag) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturating frame counters; clear beats a same-cycle increment
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_cnt_clr) begin
      rx_cnt_q   <= '0;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (head_c) begin
      if (rx_cnt_q != '1) rx_cnt_q <= rx_cnt_q + CNT_W'(1);
      if (dec_act_c == ACT_DROP) begin
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end else begin
        if (fwd_cnt_q != '1) fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      end
    end
  end

  assign ov_rx_cnt   = rx_cnt_q;
  assign ov_fwd_cnt  = fwd_cnt_q;
  assign ov_drop_cnt = drop_cnt_q;

endmodule

// File: doc/opensync_rewrite_engine.md
# opensync_rewrite_engine

- Parametrised, rule-driven OpenSync/TSMP frame rewriter inside the tsmp_agent of opentsn_hcp, between the TSMP receive path and the TSMP transmit path.
- Buffers each 9-bit byte stream in a lookahead window and decodes the subtype byte before the first byte leaves the window.
- Applies the action of the first matching rule: pass, rewrite toward a node, rewrite toward the controller, or drop.
- Maintains saturating frame counters.

## Interface
- DELAY, 32: lookahead depth in beats. Must be ≥ MATCH_OFFSET+1.
- MATCH_OFFSET, 15: byte index of the subtype field (byte 0 = first byte).
- NUM_RULES, 4: number of match rules, 1..8.
- CNT_W, 16: counter width.
- i_clk  in  1  clock; the only clock.
- i_rst_n  in  1  synchronous, active-low reset.
- iv_hcp_mac  in  48  local HCP MAC.
- iv_controller_mac  in  48  controller MAC.
- iv_rule_en  in  NUM_RULES  enable bit per rule.
- iv_rule_subtype  in  8*NUM_RULES  match value; rule r is bits [8r+7:8r].
- iv_rule_action  in  2*NUM_RULES  action per rule: 0 PASS, 1 TO_NODE, 2 TO_CTRL, 3 DROP.
- iv_rule_new_subtype  in  8*NUM_RULES  replacement subtype byte per rule.
- iv_data  in  9  bit 8 is the frame flag (set on the first and the last beat); [7:0] is the byte.
- i_data_wr  in  1  beat valid.
- ov_data  out  9  output beat.
- o_data_wr  out  1  output beat valid.
- i_cnt_clr  in  1  synchronous clear of all counters.
- ov_rx_cnt  out  CNT_W  frames decided.
- ov_fwd_cnt  out  CNT_W  frames forwarded.
- ov_drop_cnt  out  CNT_W  frames dropped, including runts.

## Operation
- Input rules: beats within a frame are contiguous (i_data_wr high throughout). The gap between frames may be 0 cycles.
- Window: DELAY stages, each holding {valid, 9-bit beat}. Absent beats shift in as valid=0, data 0.
- A head is a valid tail beat with bit 8 set while the FSM is in IDLE.
- FSM states: IDLE, HDR, BODY, DROP.
- IDLE, head at tail: decide from window position MATCH_OFFSET.
  - Runt: any of positions 1..MATCH_OFFSET is invalid or has bit 8 set → DROP; ov_drop_cnt +1.
  - Otherwise the lowest-index enabled rule whose subtype matches wins. The FSM latches action and new_subtype, so config changes mid-frame have no effect. No match → DROP.
  - ov_rx_cnt +1 on every decision.
- HDR covers bytes 0..MATCH_OFFSET. Output is the delayed beat with these overrides (bit 8 of byte 0 stays 1):
  - TO_CTRL: bytes 0–5 = iv_controller_mac MSB first; bytes 6–11 = iv_hcp_mac.
  - TO_NODE: bytes 12,13,14 = 8'hff, 8'h01, 8'h06.
  - PASS: no MAC or byte 12–14 changes.
  - All forwarding actions: byte MATCH_OFFSET = latched new_subtype.
- HDR → BODY after byte MATCH_OFFSET. BODY outputs the delayed beat unchanged.
- BODY/DROP → IDLE when the tail beat has bit 8 set (the last beat). The same cycle's next-cycle tail can be a new head.
- ov_fwd_cnt +1 at each forward decision.
- DROP suppresses o_data_wr for the whole frame.
- Counters saturate at all-ones. i_cnt_clr wins over a same-cycle increment (result 0).
- Output frame length equals input frame length.

## Timing
- Reset values: ov_data=0, o_data_wr=0, counters=0, window cleared, FSM=IDLE.
- Latency: beat k of iv_data appears on ov_data exactly DELAY+1 cycles later, for every forwarded beat.
- o_data_wr is registered and high for contiguous cycles equal to the frame length.
- Back-to-back frames leave output with 0 gap.
- Reset mid-frame: outputs go to 0 in the next cycle.
  - The remaining input beats of the cut frame still enter the window.
  - Its last beat (bit 8 set) is taken as a head and rejected as a runt; rx and drop counters each +1.
- Runt detection uses only window contents at the decision cycle; it needs no extra latency.

## Structure
- Package opensync_pkg holds:
  - action encoding (PASS/TO_NODE/TO_CTRL/DROP);
  - constants 8'hff/8'h01/8'h06;
  - subtype constants SUB_FROM_CTRL=8'h01, SUB_TO_CTRL=8'h02, SUB_TO_NODE=8'h03;
  - FSM state encoding.
- Sub-module tsmp_delay_line: parametrised DELAY-stage shift register of {valid, 9-bit beat}. Exposes the tail and a flattened window view for the decision logic.
- The rule match is a combinational priority encoder in the top module.

## Test plan
- Rule0 = {en, 8'h01, TO_NODE, 8'h03}; 64-byte frame, subtype 01:
  - output bytes 0–11 equal input, bytes 12–15 = ff 01 06 03, remainder identical;
  - byte 0 appears 33 cycles after input;
  - fwd_cnt = 1.
- Rule1 = {en, 8'h03, TO_CTRL, 8'h02}; frame with subtype 03:
  - bytes 0–5 = controller MAC, bytes 6–11 = HCP MAC, bytes 12–14 unchanged, byte 15 = 02.
- Subtype 8'h07 with no matching rule: no o_data_wr for the frame; drop_cnt = 1, rx_cnt = 1.
- 10-byte runt followed with 0 gap by a valid 64-byte frame: runt dropped; second frame forwarded intact with correct latency.
- Rules 0 and 2 both match 8'h01, with actions PASS and DROP respectively; change iv_rule_action of rule 0 mid-frame: rule 0 wins and the frame follows the latched PASS.
- Hold counters at max and inject a frame: counters stay at all-ones. Assert i_cnt_clr on the same cycle as a decision: counters read 0. Assert reset mid-frame: outputs 0 next cycle; the trailing fragment increments drop_cnt.
